// File: rtl/adder_pkg.sv
// Shared types and defaults for the sequential
// carry-lookahead adder.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_cla_adder_if.sv
// Request/result bundle between the adder
// and whoever drives it.
interface seq_cla_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/cla_slice.sv
// One GROUP-bit carry-lookahead slice; every
// carry is a flat sum of generate/propagate terms.
module cla_slice #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic cc;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      cc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      cc = cc | (pp & cin);
      c[i+1] = cc;
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one lookahead
// slice per clock, LSB slice first.
module seq_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input logic          clk,
  input logic          rst,
  seq_cla_adder_if.slave bus
);

  localparam int NGROUP = WIDTH / GROUP;
  localparam int IW = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam logic [IW-1:0] LAST = IW'(NGROUP - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [GROUP-1:0] sl_a;
  logic [GROUP-1:0] sl_b;
  logic [GROUP-1:0] sl_s;
  logic             sl_cout;
  logic             sl_c_msb;

  assign sl_a = a_r[int'(idx)*GROUP +: GROUP];
  assign sl_b = b_r[int'(idx)*GROUP +: GROUP];

  cla_slice #(
    .GROUP (GROUP)
  ) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_c_msb)
  );

  // Control FSM with registered status and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            idx    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          s_r[int'(idx)*GROUP +: GROUP] <= sl_s;
          carry <= sl_cout;
          if (idx == LAST) begin
            idx    <= '0;
            cout_r <= sl_cout;
            ovf_r  <= sl_c_msb ^ sl_cout;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx    <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed and random checks of seq_cla_adder
// in 16/4 and 8/8 configurations.
module tb_seq_cla_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_cla_adder_if #(.WIDTH(16)) bus16 ();
  seq_cla_adder_if #(.WIDTH(8))  bus8 ();

  seq_cla_adder #(.WIDTH(16), .GROUP(4)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  seq_cla_adder #(.WIDTH(8), .GROUP(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  always #5 clk = ~clk;

  task automatic go16(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic sb, output int n);
    @(negedge clk);
    bus16.a = a;
    bus16.b = b;
    bus16.cin = c;
    bus16.sub = sb;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    n = 0;
    while (!bus16.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic sb, output int n);
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.cin = c;
    bus8.sub = sb;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset16 got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf);
    end
    checks++;
    if ({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf} !== 12'h0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_carry();
    int n;
    go16(16'hFFFF, 16'h0001, 1'b0, 1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL carry_latency got %0d want 4", n);
    end
    checks++;
    if ({bus16.s, bus16.cout, bus16.ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_result got s=%h cout=%b ovf=%b want s=0000 cout=1 ovf=0",
               bus16.s, bus16.cout, bus16.ovf);
    end
    checks++;
    if (bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done got %b want 0", bus16.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus16.done, bus16.busy, bus16.s, bus16.cout} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold got done=%b busy=%b s=%h cout=%b want 0 0 0000 1",
               bus16.done, bus16.busy, bus16.s, bus16.cout);
    end
  endtask

  task automatic test_add_ovf();
    int n;
    go16(16'h7FFF, 16'h0001, 1'b0, 1'b0, n);
    checks++;
    if ({n, bus16.s, bus16.cout, bus16.ovf} !== {32'd4, 16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf got n=%0d s=%h cout=%b ovf=%b want 4 8000 0 1",
               n, bus16.s, bus16.cout, bus16.ovf);
    end
    go16(16'h1234, 16'h0F0F, 1'b1, 1'b0, n);
    checks++;
    if ({bus16.s, bus16.cout, bus16.ovf} !== {16'h2144, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_cin got s=%h cout=%b ovf=%b want 2144 0 0",
               bus16.s, bus16.cout, bus16.ovf);
    end
  endtask

  task automatic test_sub();
    int n;
    go16(16'h0005, 16'h0007, 1'b1, 1'b1, n);
    checks++;
    if ({n, bus16.s, bus16.cout, bus16.ovf} !== {32'd4, 16'hFFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow got n=%0d s=%h cout=%b ovf=%b want 4 fffe 0 0",
               n, bus16.s, bus16.cout, bus16.ovf);
    end
    go16(16'h8000, 16'h0001, 1'b0, 1'b1, n);
    checks++;
    if ({bus16.s, bus16.cout, bus16.ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf got s=%h cout=%b ovf=%b want 7fff 1 1",
               bus16.s, bus16.cout, bus16.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    bus16.a = 16'h1234;
    bus16.b = 16'h4321;
    bus16.cin = 1'b0;
    bus16.sub = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    checks++;
    if ({bus16.busy, bus16.cout, bus16.ovf} !== 3'b100) begin
      errors++;
      $display("FAIL start_capture got busy=%b cout=%b ovf=%b want 1 0 0",
               bus16.busy, bus16.cout, bus16.ovf);
    end
    @(posedge clk);
    #1;
    n = 1;
    bus16.a = 16'hFFFF;
    bus16.b = 16'hFFFF;
    bus16.cin = 1'b1;
    bus16.sub = 1'b1;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    n = 2;
    bus16.start = 1'b0;
    while (!bus16.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ({n, bus16.s, bus16.cout, bus16.ovf} !== {32'd4, 16'h5555, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start got n=%0d s=%h cout=%b ovf=%b want 4 5555 0 0",
               n, bus16.s, bus16.cout, bus16.ovf);
    end
    bus16.a = 16'h00FF;
    bus16.b = 16'h0F01;
    bus16.cin = 1'b1;
    bus16.sub = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    checks++;
    if ({bus16.done, bus16.busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept got done=%b busy=%b want 0 1",
               bus16.done, bus16.busy);
    end
    n = 0;
    while (!bus16.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ({n, bus16.s, bus16.cout, bus16.ovf} !== {32'd4, 16'h1001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result got n=%0d s=%h cout=%b ovf=%b want 4 1001 0 0",
               n, bus16.s, bus16.cout, bus16.ovf);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    @(negedge clk);
    bus16.a = 16'h1111;
    bus16.b = 16'h2222;
    bus16.cin = 1'b0;
    bus16.sub = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               bus16.busy, bus16.done, bus16.s, bus16.cout, bus16.ovf);
    end
    bus16.a = 16'h0001;
    bus16.b = 16'h0002;
    bus16.start = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus16.done) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    checks++;
    if ({seen, bus16.busy} !== {32'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_restart got dones=%0d busy=%b want 0 1", seen, bus16.busy);
    end
    n = 0;
    while (!bus16.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ({n, bus16.s, bus16.cout, bus16.ovf} !== {32'd4, 16'h0003, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_next got n=%0d s=%h cout=%b ovf=%b want 4 0003 0 0",
               n, bus16.s, bus16.cout, bus16.ovf);
    end
  endtask

  task automatic test_w8();
    int n;
    go8(8'hC8, 8'h64, 1'b1, 1'b0, n);
    checks++;
    if ({n, bus8.s, bus8.cout, bus8.ovf} !== {32'd1, 8'h2D, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w8_single got n=%0d s=%h cout=%b ovf=%b want 1 2d 1 0",
               n, bus8.s, bus8.cout, bus8.ovf);
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] bb;
    logic c;
    logic sb;
    logic [8:0] sum;
    logic ov;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 1'($urandom);
      sb = 1'($urandom);
      bb = sb ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {8'd0, (sb ? 1'b1 : c)};
      ov = (a[7] == bb[7]) && (sum[7] != a[7]);
      go8(a, b, c, sb, n);
      checks++;
      if ({n, bus8.s, bus8.cout, bus8.ovf} !== {32'd1, sum[7:0], sum[8], ov}) begin
        errors++;
        if (bad < 5)
          $display("FAIL rand a=%h b=%h cin=%b sub=%b got n=%0d s=%h c=%b v=%b want 1 %h %b %b",
                   a, b, c, sb, n, bus8.s, bus8.cout, bus8.ovf, sum[7:0], sum[8], ov);
        bad++;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus16.start = 1'b0;
    bus16.a = '0;
    bus16.b = '0;
    bus16.cin = 1'b0;
    bus16.sub = 1'b0;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus8.sub = 1'b0;
    test_reset();
    test_add_carry();
    test_add_ovf();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
